// File: rtl/stack_access_ctrl_pkg.sv
// Shared CPU hardware-stack constants and the stack front-end FSM state encoding.
package stack_access_ctrl_pkg;

    localparam int unsigned STACK_DEPTH = 128;
    localparam int unsigned STACK_PTR_W = 7;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPopWait = 2'd1,
        StUfRsp   = 2'd2
    } stack_state_e;

endpackage

// File: rtl/stack_depth_tracker.sv
// Occupancy counter for the hardware stack; guards increments/decrements against
// overflow and underflow so the count never wraps.
module stack_depth_tracker
    import stack_access_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = STACK_DEPTH,
    parameter int unsigned PTR_W = STACK_PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [PTR_W:0]   depth,
    output logic             full,
    output logic             empty,
    output logic             inc_ok,
    output logic             dec_ok,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR_W:0] DepthMax = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] One      = (PTR_W + 1)'(1);

    logic [PTR_W:0] depth_q, depth_d;

    always_comb begin
        full      = (depth_q == DepthMax);
        empty     = (depth_q == '0);
        inc_ok    = inc && !full;
        dec_ok    = dec && !empty;
        overflow  = inc && full;
        underflow = dec && empty;
        depth     = depth_q;
        depth_d   = depth_q;
        if (inc_ok) begin
            depth_d = depth_q + One;
        end else if (dec_ok) begin
            depth_d = depth_q - One;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/stack_access_ctrl.sv
// Front-end between the EX-stage PUSH/POP decode and the stack memory: occupancy,
// sticky overflow/underflow flags and the 1-cycle pop response sequencing.
module stack_access_ctrl
    import stack_access_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = STACK_DEPTH,
    parameter int unsigned PTR_W  = STACK_PTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_pop,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              hold,
    input  logic              flush,
    input  logic              err_clear,
    output logic [DATA_W-1:0] stk_d,
    output logic              stk_push,
    output logic              stk_pop,
    input  logic [DATA_W-1:0] stk_q,
    output logic              stk_hold,
    output logic              stk_clear,
    output logic [PTR_W:0]    depth,
    output logic              full,
    output logic              empty,
    output logic              err_overflow,
    output logic              err_underflow
);

    stack_state_e state_q, state_d;
    logic         ovf_q, unf_q;
    logic         push_acc, pop_acc;
    logic         inc_ok, dec_ok, overflow, underflow;

    assign stk_hold  = hold;
    assign stk_clear = flush;
    assign stk_d     = req_data;

    assign req_ready = (state_q == StIdle) && !hold && !flush;
    assign push_acc  = req_valid && req_ready && !req_pop;
    assign pop_acc   = req_valid && req_ready && req_pop;

    assign stk_push  = inc_ok;
    assign stk_pop   = dec_ok;

    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

    stack_depth_tracker #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_depth (
        .clk       (clk),
        .reset     (reset),
        .inc       (push_acc),
        .dec       (pop_acc),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .inc_ok    (inc_ok),
        .dec_ok    (dec_ok),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_comb begin
        state_d   = state_q;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        unique case (state_q)
            StIdle: begin
                if (pop_acc) begin
                    state_d = dec_ok ? StPopWait : StUfRsp;
                end
            end
            StPopWait: begin
                // The stack holds q while stalled, so the response stays stable.
                rsp_valid = !flush;
                rsp_data  = flush ? '0 : stk_q;
                if (flush || !hold) begin
                    state_d = StIdle;
                end
            end
            StUfRsp: begin
                rsp_valid = !flush;
                if (flush || !hold) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // A new error in the same cycle as err_clear wins.
            ovf_q   <= overflow  || (ovf_q && !err_clear);
            unf_q   <= underflow || (unf_q && !err_clear);
        end
    end

endmodule

// File: tb/tb_stack_access_ctrl.sv
// Scoreboard bench for stack_access_ctrl: stack memory stand-in, queue-based reference
// model, and a monitor that checks every response cycle against expected responses.
module tb_stack_access_ctrl;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_pop, req_ready;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        hold, flush, err_clear;
    logic [31:0] stk_d, stk_q;
    logic        stk_push, stk_pop, stk_hold, stk_clear;
    logic [7:0]  depth;
    logic        full, empty, err_overflow, err_underflow;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    logic [31:0] sb[$];

    // Reference model state
    logic [31:0] m_stk[$];
    bit          m_ovf, m_unf, m_pend;
    logic [31:0] m_pend_val;

    // Stack memory stand-in: registered pop output, held on stall, zeroed on clear
    logic [31:0] mem[DEPTH];
    logic [7:0]  sp;

    always #5 clk = ~clk;

    stack_access_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_pop       (req_pop),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .hold          (hold),
        .flush         (flush),
        .err_clear     (err_clear),
        .stk_d         (stk_d),
        .stk_push      (stk_push),
        .stk_pop       (stk_pop),
        .stk_q         (stk_q),
        .stk_hold      (stk_hold),
        .stk_clear     (stk_clear),
        .depth         (depth),
        .full          (full),
        .empty         (empty),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always @(posedge clk) begin
        if (reset) begin
            sp    <= '0;
            stk_q <= '0;
        end else if (stk_clear) begin
            stk_q <= '0;
        end else if (!stk_hold) begin
            if (stk_push) begin
                mem[7'(sp)] <= stk_d;
                sp          <= sp + 8'd1;
            end else if (stk_pop) begin
                stk_q <= mem[7'(sp - 8'd1)];
                sp    <= sp - 8'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT must present exactly the response the model queued.
    always @(negedge clk) begin
        logic [31:0] e;
        if (mon_en) begin
            chk("rsp_valid", 64'(rsp_valid), 64'(sb.size() > 0));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (rsp_valid === 1'b1) chk("rsp_data", 64'(rsp_data), 64'(e));
            end
        end
    end

    // One clock cycle of stimulus; checks same-cycle outputs, then advances the model.
    task automatic step(input bit rst, input bit rv, input bit rp, input logic [31:0] d,
                        input bit h, input bit fl, input bit ec);
        bit e_ready, acc, e_push, e_pop;
        int sz;
        @(posedge clk);
        #1;
        reset = rst; req_valid = rv; req_pop = rp; req_data = d;
        hold = h; flush = fl; err_clear = ec;
        sz      = m_stk.size();
        e_ready = !m_pend && !h && !fl;
        acc     = rv && e_ready;
        e_push  = acc && !rp && (sz < DEPTH);
        e_pop   = acc && rp && (sz > 0);
        if (m_pend && !fl) sb.push_back(m_pend_val);
        #1;
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("stk_push", 64'(stk_push), 64'(e_push));
        chk("stk_pop", 64'(stk_pop), 64'(e_pop));
        chk("depth", 64'(depth), 64'(sz));
        chk("full", 64'(full), 64'(sz == DEPTH));
        chk("empty", 64'(empty), 64'(sz == 0));
        chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
        chk("err_underflow", 64'(err_underflow), 64'(m_unf));
        chk("stk_hold", 64'(stk_hold), 64'(h));
        chk("stk_clear", 64'(stk_clear), 64'(fl));
        if (e_push) chk("stk_d", 64'(stk_d), 64'(d));
        if (rst) begin
            m_stk.delete();
            m_ovf  = 0;
            m_unf  = 0;
            m_pend = 0;
        end else begin
            if (m_pend && (fl || !h)) m_pend = 0;
            m_ovf = (acc && !rp && sz == DEPTH) || (m_ovf && !ec);
            m_unf = (acc && rp && sz == 0) || (m_unf && !ec);
            if (e_push) m_stk.push_back(d);
            if (acc && rp) begin
                m_pend     = 1;
                m_pend_val = e_pop ? m_stk.pop_back() : 32'h0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 0, 0);
    endtask

    initial begin
        int pop_pct;
        reset = 1'b1; req_valid = 0; req_pop = 0; req_data = '0;
        hold = 0; flush = 0; err_clear = 0;
        m_stk.delete(); m_ovf = 0; m_unf = 0; m_pend = 0; m_pend_val = '0;
        @(posedge clk);
        mon_en = 1'b1;
        step(1, 0, 0, 32'h0, 0, 0, 0);

        // Three back-to-back pushes, then two pops with a blocked request in between
        step(0, 1, 0, 32'h11, 0, 0, 0);
        step(0, 1, 0, 32'h22, 0, 0, 0);
        step(0, 1, 0, 32'h33, 0, 0, 0);
        step(0, 1, 1, 32'h0, 0, 0, 0);
        step(0, 1, 1, 32'h0, 0, 0, 0);
        step(0, 1, 1, 32'h0, 0, 0, 0);
        idle(2);

        // Fill to full, one overflowing push, then clear the flag
        step(1, 0, 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, $urandom, 0, 0, 0);
        step(0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0);
        step(0, 0, 0, 32'h0, 0, 0, 1);
        idle(1);

        // Pop on empty
        step(1, 0, 0, 32'h0, 0, 0, 0);
        step(0, 1, 1, 32'h0, 0, 0, 0);
        idle(2);

        // Pop held for three cycles
        step(0, 1, 0, 32'hA5A5_0001, 0, 0, 0);
        step(0, 1, 0, 32'h5A5A_0002, 0, 0, 0);
        step(0, 1, 1, 32'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 1, 0, 0);
        idle(2);

        // Flush in POP_WAIT, then reset in POP_WAIT
        step(0, 1, 1, 32'h0, 0, 0, 0);
        step(0, 0, 0, 32'h0, 0, 1, 0);
        idle(1);
        step(0, 1, 0, 32'hC0DE_0003, 0, 0, 0);
        step(0, 1, 1, 32'h0, 0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0, 0);
        idle(2);

        // Randomized traffic, alternating push-heavy and pop-heavy phases
        for (int i = 0; i < 3000; i++) begin
            pop_pct = ((i / 400) % 2 == 0) ? 15 : 80;
            step(($urandom_range(999) < 3),
                 ($urandom_range(99) < 75),
                 ($urandom_range(99) < pop_pct),
                 $urandom,
                 ($urandom_range(99) < 15),
                 ($urandom_range(99) < 8),
                 ($urandom_range(99) < 5));
        end
        idle(2);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
